reg_scoreboard: RTL and testbench

//  Tracks pending register-file writes for the 8x16-bit register file; sits beside decode.

---
 rtl/reg_scoreboard_pkg.sv | 24 ++
 rtl/reg_scoreboard_sb_counter.sv | 33 +++
 rtl/reg_scoreboard.sv | 100 ++++++++++
 tb/tb_reg_scoreboard.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// reg_scoreboard_pkg
//   Shared constants and types for the register scoreboard.
//   - SB_NREGS / SB_REG_W : architectural register count and index width
//   - SB_LAT_W / SB_PERF_W: default latency-counter and perf-counter widths
//   - LAT_ALU / LAT_MEM   : issue latency per opcode class
//   - hazard_t            : decoded hazard flags for the instruction in decode
// ----------------------------------------------------------------------------
package reg_scoreboard_pkg;

    localparam int unsigned SB_NREGS  = 8;
    localparam int unsigned SB_REG_W  = 3;
    localparam int unsigned SB_LAT_W  = 2;
    localparam int unsigned SB_PERF_W = 16;

    localparam logic [SB_LAT_W-1:0] LAT_ALU = 2'd1;
    localparam logic [SB_LAT_W-1:0] LAT_MEM = 2'd2;

    typedef struct packed {
        logic raw;
        logic waw;
    } hazard_t;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// ----------------------------------------------------------------------------
// sb_counter
//   Per-register pending-write countdown. Loads the issue latency of a newly
//   accepted write, otherwise counts down to zero and stays there.
//   Ports:
//     clk      in   clock
//     rst      in   synchronous active-high reset (clears the count)
//     load     in   accept a new write for this register
//     load_val in   latency to load
//     count    out  cycles remaining until the pending write retires
// ----------------------------------------------------------------------------
module sb_counter #(
    parameter int unsigned LAT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            // a newly accepted write replaces whatever was pending
            count <= load_val;
        end else if (count != '0) begin
            count <= count - LAT_W'(1);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
//   Tracks pending register-file writes beside decode and decides each cycle
//   whether the decoded instruction may issue or must stall on a RAW/WAW
//   hazard. Flags operands to be taken from the writeback bypass and keeps a
//   saturating count of stall cycles.
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     issue_valid                decode holds a valid instruction
//     use1/use2, Rsrc1/Rsrc2     source operand enables and indices
//     issue_wr, Rdst, issue_lat  destination write enable, index, latency
//     flush                      squash decode this cycle
//     stall, issue_ok            combinational issue decision
//     fwd1, fwd2                 combinational bypass selects
//     busy_mask                  bit r set while register r has a pending write
//     stall_cycles               saturating stall-cycle counter (registered)
// ----------------------------------------------------------------------------
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS  = SB_NREGS,
    parameter int unsigned REG_W  = SB_REG_W,
    parameter int unsigned LAT_W  = SB_LAT_W,
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned PERF_W = SB_PERF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              use1,
    input  logic              use2,
    input  logic [REG_W-1:0]  Rsrc1,
    input  logic [REG_W-1:0]  Rsrc2,
    input  logic              issue_wr,
    input  logic [REG_W-1:0]  Rdst,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic              flush,
    output logic              stall,
    output logic              issue_ok,
    output logic              fwd1,
    output logic              fwd2,
    output logic [NREGS-1:0]  busy_mask,
    output logic [PERF_W-1:0] stall_cycles
);

    logic [LAT_W-1:0] cnt [NREGS];
    hazard_t          hz;
    logic             front_ok;

    // A source is ready once its writer retires, or one cycle earlier when
    // the result can be picked up from the writeback bypass.
    function automatic logic is_ready(input logic [LAT_W-1:0] c);
        return (c == '0) || (FWD_EN && (c == LAT_W'(1)));
    endfunction

    for (genvar g = 0; g < NREGS; g++) begin : g_cnt
        logic load;

        assign load = issue_ok && issue_wr && (issue_lat != '0) &&
                      (Rdst == REG_W'(g));

        sb_counter #(.LAT_W(LAT_W)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .load_val (issue_lat),
            .count    (cnt[g])
        );
    end

    // Hazards are evaluated against pre-edge counts, so an instruction whose
    // source equals its destination only sees older writers.
    always_comb begin
        hz       = '0;
        hz.raw   = (use1 && !is_ready(cnt[Rsrc1])) ||
                   (use2 && !is_ready(cnt[Rsrc2]));
        hz.waw   = issue_wr && (issue_lat != '0) && (cnt[Rdst] > issue_lat);
        front_ok = issue_valid && !flush && !rst;
        stall    = front_ok && (hz.raw || hz.waw);
        issue_ok = front_ok && !(hz.raw || hz.waw);
        fwd1     = use1 && FWD_EN && (cnt[Rsrc1] == LAT_W'(1));
        fwd2     = use2 && FWD_EN && (cnt[Rsrc2] == LAT_W'(1));
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       rst, issue_valid, use1, use2, issue_wr, flush;
    logic [2:0] Rsrc1, Rsrc2, Rdst;
    logic [1:0] issue_lat;

    logic        stall, issue_ok, fwd1, fwd2;
    logic [7:0]  busy_mask;
    logic [15:0] stall_cycles;

    logic        s_stall, s_issue_ok, s_fwd1, s_fwd2;
    logic [7:0]  s_busy_mask;
    logic [3:0]  s_stall_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .use1(use1), .use2(use2),
        .Rsrc1(Rsrc1), .Rsrc2(Rsrc2), .issue_wr(issue_wr), .Rdst(Rdst),
        .issue_lat(issue_lat), .flush(flush), .stall(stall), .issue_ok(issue_ok),
        .fwd1(fwd1), .fwd2(fwd2), .busy_mask(busy_mask), .stall_cycles(stall_cycles)
    );

    // Second instance: no bypass and a narrow perf counter to reach saturation.
    reg_scoreboard #(.FWD_EN(1'b0), .PERF_W(4)) dut_s (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .use1(use1), .use2(use2),
        .Rsrc1(Rsrc1), .Rsrc2(Rsrc2), .issue_wr(issue_wr), .Rdst(Rdst),
        .issue_lat(issue_lat), .flush(flush), .stall(s_stall), .issue_ok(s_issue_ok),
        .fwd1(s_fwd1), .fwd2(s_fwd2), .busy_mask(s_busy_mask),
        .stall_cycles(s_stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst, valid, u1, u2;
        logic [2:0] s1, s2;
        logic       wr;
        logic [2:0] dst;
        logic [1:0] lat;
        logic       flush;
        logic       e_stall, e_ok, e_f1, e_f2;
        logic [7:0] e_busy;
        logic [15:0] e_sc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int r, int v, int u1, int u2, int s1, int s2, int wr,
                                int dst, int lat, int fl, int es, int eo, int ef1,
                                int ef2, int eb, int esc);
        vec_t x;
        x.rst = 1'(r);  x.valid = 1'(v); x.u1 = 1'(u1); x.u2 = 1'(u2);
        x.s1 = 3'(s1);  x.s2 = 3'(s2);   x.wr = 1'(wr); x.dst = 3'(dst);
        x.lat = 2'(lat); x.flush = 1'(fl);
        x.e_stall = 1'(es); x.e_ok = 1'(eo); x.e_f1 = 1'(ef1); x.e_f2 = 1'(ef2);
        x.e_busy = 8'(eb); x.e_sc = 16'(esc);
        return x;
    endfunction

    // Reference model: each register remembers the absolute cycle at which its
    // pending write retires; remaining latency is that cycle minus "now".
    longint t;
    longint rdy [2][8];
    int     sc_m [2];
    int     sc_max [2] = '{65535, 15};
    int     fwd_lim [2] = '{1, 0};

    function automatic int rem(int d, int r);
        return (rdy[d][r] > t) ? int'(rdy[d][r] - t) : 0;
    endfunction

    task automatic model_reset();
        t = 0;
        for (int d = 0; d < 2; d++) begin
            sc_m[d] = 0;
            for (int r = 0; r < 8; r++) rdy[d][r] = 0;
        end
    endtask

    task automatic model_cycle(input string tag);
        bit st_m [2];
        bit ok_m [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            bit raw, waw, front, st, ok, f1, f2;
            logic [7:0] eb;
            raw   = (use1 && rem(d, int'(Rsrc1)) > fwd_lim[d]) ||
                    (use2 && rem(d, int'(Rsrc2)) > fwd_lim[d]);
            waw   = issue_wr && issue_lat != 0 && rem(d, int'(Rdst)) > int'(issue_lat);
            front = issue_valid && !flush && !rst;
            st    = front && (raw || waw);
            ok    = front && !st;
            f1    = use1 && fwd_lim[d] == 1 && rem(d, int'(Rsrc1)) == 1;
            f2    = use2 && fwd_lim[d] == 1 && rem(d, int'(Rsrc2)) == 1;
            for (int r = 0; r < 8; r++) eb[r] = (rem(d, r) != 0);
            chk($sformatf("%s_d%0d_stall", tag, d), d == 0 ? stall : s_stall, st);
            chk($sformatf("%s_d%0d_ok", tag, d), d == 0 ? issue_ok : s_issue_ok, ok);
            chk($sformatf("%s_d%0d_busy", tag, d), d == 0 ? busy_mask : s_busy_mask, eb);
            chk($sformatf("%s_d%0d_sc", tag, d),
                d == 0 ? 32'(stall_cycles) : 32'(s_stall_cycles), sc_m[d]);
            if (ok) begin
                chk($sformatf("%s_d%0d_fwd1", tag, d), d == 0 ? fwd1 : s_fwd1, f1);
                chk($sformatf("%s_d%0d_fwd2", tag, d), d == 0 ? fwd2 : s_fwd2, f2);
            end
            st_m[d] = st;
            ok_m[d] = ok;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                sc_m[d] = 0;
                for (int r = 0; r < 8; r++) rdy[d][r] = 0;
            end else begin
                if (st_m[d] && sc_m[d] < sc_max[d]) sc_m[d]++;
                if (ok_m[d] && issue_wr && issue_lat != 0)
                    rdy[d][Rdst] = t + 1 + longint'(issue_lat);
            end
        end
        t++;
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic u1, input logic u2,
                         input logic [2:0] s1, input logic [2:0] s2, input logic wr,
                         input logic [2:0] dst, input logic [1:0] lat, input logic fl);
        rst = r; issue_valid = v; use1 = u1; use2 = u2; Rsrc1 = s1; Rsrc2 = s2;
        issue_wr = wr; Rdst = dst; issue_lat = lat; flush = fl;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        //               r v u1 u2 s1 s2 wr d lat fl | st ok f1 f2 busy sc
        tbl.push_back(mk(1,1,1,0, 3,0, 0,0,0,      0,  0,0,0,0, 'h00,0)); // reset gates outputs
        tbl.push_back(mk(0,1,0,0, 0,0, 1,3,LAT_ALU,0,  0,1,0,0, 'h00,0));
        tbl.push_back(mk(0,1,1,0, 3,0, 0,0,0,      0,  0,1,1,0, 'h08,0)); // bypass R3
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,      0,  0,0,0,0, 'h00,0));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,5,LAT_MEM,0,  0,1,0,0, 'h00,0));
        tbl.push_back(mk(0,1,0,1, 0,5, 0,0,0,      0,  1,0,0,0, 'h20,0)); // raw on R5
        tbl.push_back(mk(0,1,0,1, 0,5, 0,0,0,      0,  0,1,0,1, 'h20,1));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,2,LAT_MEM,0,  0,1,0,0, 'h00,1));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,2,LAT_ALU,0,  1,0,0,0, 'h04,1)); // waw 2>1
        tbl.push_back(mk(0,1,0,0, 0,0, 1,2,LAT_ALU,0,  0,1,0,0, 'h04,2));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,2,LAT_MEM,0,  0,1,0,0, 'h04,2));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,2,LAT_MEM,0,  0,1,0,0, 'h04,2)); // equal: no waw
        tbl.push_back(mk(0,1,0,0, 0,0, 1,2,3,      0,  0,1,0,0, 'h04,2));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,2,LAT_MEM,0,  1,0,0,0, 'h04,2)); // waw 3>2
        tbl.push_back(mk(0,1,0,0, 0,0, 1,2,0,      0,  0,1,0,0, 'h04,3)); // untracked
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,      0,  0,0,0,0, 'h04,3));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,6,3,      0,  0,1,0,0, 'h00,3));
        tbl.push_back(mk(0,1,1,0, 6,0, 1,4,LAT_MEM,1,  0,0,0,0, 'h40,3)); // flush
        tbl.push_back(mk(0,1,1,0, 6,0, 0,0,0,      0,  1,0,0,0, 'h40,3));
        tbl.push_back(mk(0,1,1,0, 6,0, 0,0,0,      0,  0,1,1,0, 'h40,4));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,7,LAT_MEM,0,  0,1,0,0, 'h00,4)); // R4 never loaded
        tbl.push_back(mk(0,1,0,0, 0,0, 1,1,LAT_MEM,0,  0,1,0,0, 'h80,4));
        tbl.push_back(mk(1,1,1,0, 1,0, 0,0,0,      0,  0,0,0,0, 'h82,4)); // rst mid-flight
        tbl.push_back(mk(0,1,1,0, 1,0, 0,0,0,      0,  0,1,0,0, 'h00,0));
        tbl.push_back(mk(0,1,1,0, 4,0, 1,4,LAT_MEM,0,  0,1,0,0, 'h00,0)); // src==dst
        tbl.push_back(mk(0,1,1,1, 4,4, 1,4,LAT_ALU,0,  1,0,0,0, 'h10,0));
        tbl.push_back(mk(0,1,1,1, 4,4, 1,4,LAT_ALU,0,  0,1,1,1, 'h10,1));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,      0,  0,0,0,0, 'h10,1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].u1, tbl[i].u2, tbl[i].s1, tbl[i].s2,
                  tbl[i].wr, tbl[i].dst, tbl[i].lat, tbl[i].flush);
            @(negedge clk);
            chk($sformatf("row%0d_stall", i), stall, tbl[i].e_stall);
            chk($sformatf("row%0d_ok", i), issue_ok, tbl[i].e_ok);
            chk($sformatf("row%0d_fwd1", i), fwd1, tbl[i].e_f1);
            chk($sformatf("row%0d_fwd2", i), fwd2, tbl[i].e_f2);
            chk($sformatf("row%0d_busy", i), busy_mask, tbl[i].e_busy);
            chk($sformatf("row%0d_sc", i), stall_cycles, tbl[i].e_sc);
            @(posedge clk);
            #1;
        end

        // Randomized run against the reference model, both instances.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                  1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 3'($urandom), 2'($urandom),
                  $urandom_range(0, 7) == 0);
            model_cycle("rnd");
        end

        // Repeated hazards on R0 to drive the narrow counter into saturation.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0);
        model_cycle("sat_rst");
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 2'd3, 1'b0);
            model_cycle("sat_wr");
            for (int j = 0; j < 3; j++) begin
                drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0);
                model_cycle("sat_rd");
            end
        end
        @(negedge clk);
        chk("sat_narrow_held", s_stall_cycles, 4'hF);
        chk("sat_wide_count", stall_cycles, 16'd80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
